operator_scheduler: RTL and testbench

- Sequences the phase/modulator pipeline: on each sample tick, issues every voice-operator ID, one per clock, then waits for the pipeline to drain before signalling frame completion.
- Owns the algorithm configuration write port of the modulator stage. Host writes are buffered in a small FIFO and applied only between frames, so no algorithm word changes while a frame is in flight.
- Sits between the sample-rate timer/host register interface and the head of the operator pipeline.

---
 rtl/operator_scheduler_if.sv | 34 +++
 rtl/operator_scheduler.sv | 119 +++++++++++
 tb/tb_operator_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/operator_scheduler_if.sv
// Host/pipeline-facing signal bundle of operator_scheduler: tick, config write
// port, operator issue stream and modulator algorithm write port.
interface operator_scheduler_if #(
  parameter int ID_WIDTH = 7
);
  logic                i_SampleTick;
  logic [ID_WIDTH-1:0] o_VoiceOperator;
  logic                o_VoiceOperatorValid;
  logic                o_FrameBusy;
  logic                o_FrameDone;
  logic                o_Overrun;
  logic                i_CfgValid;
  logic                o_CfgReady;
  logic [1:0]          i_CfgEnable;
  logic [ID_WIDTH-1:0] i_CfgAddr;
  logic [7:0]          i_CfgData;
  logic [1:0]          o_AlgorithmWriteEnable;
  logic [ID_WIDTH-1:0] o_AlgorithmWriteAddr;
  logic [7:0]          o_AlgorithmWriteData;

  modport slave (
    input  i_SampleTick, i_CfgValid, i_CfgEnable, i_CfgAddr, i_CfgData,
    output o_VoiceOperator, o_VoiceOperatorValid, o_FrameBusy, o_FrameDone,
           o_Overrun, o_CfgReady, o_AlgorithmWriteEnable, o_AlgorithmWriteAddr,
           o_AlgorithmWriteData
  );

  modport master (
    output i_SampleTick, i_CfgValid, i_CfgEnable, i_CfgAddr, i_CfgData,
    input  o_VoiceOperator, o_VoiceOperatorValid, o_FrameBusy, o_FrameDone,
           o_Overrun, o_CfgReady, o_AlgorithmWriteEnable, o_AlgorithmWriteAddr,
           o_AlgorithmWriteData
  );
endinterface

// File: rtl/operator_scheduler.sv
// Frame sequencer for the operator pipeline plus between-frame config apply FIFO.
// Optional OPERATOR_SCHEDULER_TICK_QUEUE_EN holds one tick that arrives mid-frame.
module operator_scheduler #(
  parameter int NUM_VOICE_OPERATORS = 128,
  parameter int ID_WIDTH            = 7,
  parameter int PIPELINE_DEPTH      = 12,
  parameter int CFG_FIFO_DEPTH      = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  operator_scheduler_if.slave  bus
);
  localparam int PW = $clog2(CFG_FIFO_DEPTH);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_VOICE_OPERATORS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic [1:0]          en;
    logic [ID_WIDTH-1:0] addr;
    logic [7:0]          data;
  } cfg_t;

  state_t              state;
  logic [ID_WIDTH-1:0] op_id;
  logic                op_vld, busy, done, overrun;
  logic [7:0]          drain_cnt;
  cfg_t                wr_out;
  cfg_t                fifo [CFG_FIFO_DEPTH];
  logic [PW:0]         wr_ptr, rd_ptr, count;
  logic                cfg_ready, push, pop, start_frame, pend;

  assign count       = wr_ptr - rd_ptr;
  assign cfg_ready   = (count != (PW+1)'(CFG_FIFO_DEPTH));
  assign push        = bus.i_CfgValid && cfg_ready;
  assign start_frame = (state == IDLE) && (bus.i_SampleTick || pend);
  // A frame start always wins over applying a config word.
  assign pop         = (state == IDLE) && !start_frame && (count != '0);

`ifndef OPERATOR_SCHEDULER_TICK_QUEUE_EN
  assign pend = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= '{bus.i_CfgEnable, bus.i_CfgAddr, bus.i_CfgData};
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= IDLE;
      op_id     <= '0;
      op_vld    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      drain_cnt <= '0;
      wr_out    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
`ifdef OPERATOR_SCHEDULER_TICK_QUEUE_EN
      pend      <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      wr_out <= '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        wr_out <= fifo[rd_ptr[PW-1:0]];
      end
      case (state)
        IDLE: if (start_frame) begin
          state  <= ISSUE;
          op_id  <= '0;
          op_vld <= 1'b1;
          busy   <= 1'b1;
`ifdef OPERATOR_SCHEDULER_TICK_QUEUE_EN
          // Pending and live tick together: one starts now, the other stays queued.
          pend   <= pend && bus.i_SampleTick;
`endif
        end
        ISSUE: if (op_id == LAST_ID) begin
          state     <= DRAIN;
          op_id     <= '0;
          op_vld    <= 1'b0;
          drain_cnt <= 8'(PIPELINE_DEPTH);
        end else begin
          op_id <= op_id + 1'b1;
        end
        DRAIN: if (drain_cnt == 8'd1) begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          drain_cnt <= '0;
        end else begin
          drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE && bus.i_SampleTick) begin
`ifdef OPERATOR_SCHEDULER_TICK_QUEUE_EN
        if (pend) overrun <= 1'b1;
        else      pend    <= 1'b1;
`else
        overrun <= 1'b1;
`endif
      end
    end
  end

  assign bus.o_VoiceOperator        = op_id;
  assign bus.o_VoiceOperatorValid   = op_vld;
  assign bus.o_FrameBusy            = busy;
  assign bus.o_FrameDone            = done;
  assign bus.o_Overrun              = overrun;
  assign bus.o_CfgReady             = cfg_ready;
  assign bus.o_AlgorithmWriteEnable = wr_out.en;
  assign bus.o_AlgorithmWriteAddr   = wr_out.addr;
  assign bus.o_AlgorithmWriteData   = wr_out.data;
endmodule

// File: tb/tb_operator_scheduler.sv
// Directed + random bench for operator_scheduler against a frame-phase/queue model.
module tb_operator_scheduler;
  localparam int N  = 128;
  localparam int PD = 12;
  localparam int D  = 4;

  typedef struct packed {
    logic [1:0] en;
    logic [6:0] a;
    logic [7:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operator_scheduler_if #(.ID_WIDTH(7)) bus();
  operator_scheduler #(
    .NUM_VOICE_OPERATORS(N), .ID_WIDTH(7), .PIPELINE_DEPTH(PD), .CFG_FIFO_DEPTH(D)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .bus(bus)
  );

  int   total = 0, bad = 0;
  ent_t mq[$];
  ent_t obs_w[$];
  int   obs_wc[$];
  int   phase = -1;
  bit   m_ovr = 0, m_pend = 0, e_done = 0, last_acc = 0;
  ent_t e_w = '0;
  int   cyc = 0, nvalid = 0, ndone = 0, done_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rnd();
    ent_t r;
    r = 17'($urandom);
    return r;
  endfunction

  function automatic ent_t rnd_w();
    ent_t r;
    r = rnd();
    r.en = 2'($urandom_range(1, 3));
    return r;
  endfunction

  // One clock: drive, advance model at the edge, compare all outputs on the falling edge.
  task automatic step(input bit tk, input bit cv, input ent_t ce, input bit r);
    ent_t pe;
    logic [28:0] ev, ov;
    bit ev_vld;
    rst = r;
    bus.i_SampleTick = tk;
    bus.i_CfgValid   = cv;
    {bus.i_CfgEnable, bus.i_CfgAddr, bus.i_CfgData} = ce;
    @(posedge clk);
    e_done = 0;
    e_w    = '0;
    if (r) begin
      phase = -1; mq.delete(); m_ovr = 0; m_pend = 0; last_acc = 0;
    end else begin
      last_acc = cv && (mq.size() < D);
      if (phase >= 0) begin
        if (tk) begin
`ifdef OPERATOR_SCHEDULER_TICK_QUEUE_EN
          if (m_pend) m_ovr = 1; else m_pend = 1;
`else
          m_ovr = 1;
`endif
        end
        phase++;
        if (phase == N + PD) begin phase = -1; e_done = 1; end
      end else if (tk || m_pend) begin
        phase  = 0;
        m_pend = m_pend && tk;
      end else if (mq.size() > 0) begin
        pe  = mq.pop_front();
        e_w = pe;
      end
      if (last_acc) mq.push_back(ce);
    end
    @(negedge clk);
    cyc++;
    ev_vld = (phase >= 0) && (phase < N);
    ev = {ev_vld, ev_vld ? 7'(phase) : 7'd0, phase >= 0, e_done, m_ovr, e_w, mq.size() < D};
    ov = {bus.o_VoiceOperatorValid, bus.o_VoiceOperator, bus.o_FrameBusy, bus.o_FrameDone,
          bus.o_Overrun, bus.o_AlgorithmWriteEnable, bus.o_AlgorithmWriteAddr,
          bus.o_AlgorithmWriteData, bus.o_CfgReady};
    check("outs", 32'(ov), 32'(ev));
    if (bus.o_VoiceOperatorValid === 1'b1) nvalid++;
    if (bus.o_FrameDone === 1'b1) begin ndone++; done_cyc = cyc; end
    if (bus.o_AlgorithmWriteEnable !== 2'b00) begin
      obs_w.push_back({bus.o_AlgorithmWriteEnable, bus.o_AlgorithmWriteAddr, bus.o_AlgorithmWriteData});
      obs_wc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, rnd(), 0);
  endtask

  task automatic push_hold(input ent_t e);
    int k = 0;
    do begin step(0, 1, e, 0); k++; end while (!last_acc && k < 400);
    check("push_accept", 32'(last_acc), 32'd1);
  endtask

  task automatic run_to_done();
    int s = ndone, k = 0;
    while (ndone == s && k < 500) begin step(0, 0, rnd(), 0); k++; end
    check("done_seen", 32'(ndone - s), 32'd1);
  endtask

  initial begin
    ent_t exp_q[$];
    int c0, nd0, w0, k;
    bus.i_SampleTick = 0; bus.i_CfgValid = 0;
    bus.i_CfgEnable = 0; bus.i_CfgAddr = 0; bus.i_CfgData = 0;
    rst = 1;
    for (int i = 0; i < 3; i++) step(0, 0, rnd(), 1);
    check("reset_outs", 32'({bus.o_VoiceOperatorValid, bus.o_FrameBusy, bus.o_FrameDone, bus.o_Overrun,
                             bus.o_AlgorithmWriteEnable, bus.o_CfgReady}), 32'h1);
    idle(4);

    // single frame: ID count and tick-to-done length
    nvalid = 0; ndone = 0; c0 = cyc;
    step(1, 0, rnd(), 0);
    idle(160);
    check("id_count", 32'(nvalid), 32'(N));
    check("frame_done_cnt", 32'(ndone), 32'd1);
    check("frame_len", 32'(done_cyc - c0), 32'(N + PD + 1));

    // three writes mid-frame, applied back to back after done
    obs_w.delete(); obs_wc.delete(); exp_q.delete();
    step(1, 0, rnd(), 0);
    idle(20);
    exp_q.push_back({2'b01, 7'd5, 8'h2A});
    exp_q.push_back({2'b10, 7'd5, 8'h0B});
    exp_q.push_back({2'b11, 7'd127, 8'hFF});
    foreach (exp_q[i]) push_hold(exp_q[i]);
    run_to_done();
    idle(8);
    check("w3_count", 32'(obs_w.size()), 32'd3);
    for (int i = 0; i < 3 && i < obs_w.size(); i++) begin
      check("w3_data", 32'(obs_w[i]), 32'(exp_q[i]));
      check("w3_cycle", 32'(obs_wc[i]), 32'(done_cyc + 1 + i));
    end

    // five writes into a depth-4 FIFO while busy
    obs_w.delete(); obs_wc.delete(); exp_q.delete();
    step(1, 0, rnd(), 0);
    idle(5);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(rnd_w());
      push_hold(exp_q[i]);
      if (i == 3) check("ready_full", 32'(bus.o_CfgReady), 32'd0);
    end
    idle(10);
    check("w5_count", 32'(obs_w.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_w.size(); i++) check("w5_data", 32'(obs_w[i]), 32'(exp_q[i]));

    // tick lands on the cycle a pop would happen
    obs_w.delete(); obs_wc.delete(); exp_q.delete();
    step(1, 0, rnd(), 0);
    idle(5);
    for (int i = 0; i < 2; i++) begin exp_q.push_back(rnd_w()); push_hold(exp_q[i]); end
    run_to_done();
    step(1, 0, rnd(), 0);
    check("tick_prio_busy", 32'({bus.o_FrameBusy, bus.o_AlgorithmWriteEnable}), 32'h4);
    run_to_done();
    check("tick_prio_nowr", 32'(obs_w.size()), 32'd0);
    idle(5);
    check("tick_prio_w", 32'(obs_w.size()), 32'd2);
    for (int i = 0; i < 2 && i < obs_w.size(); i++) check("tick_prio_data", 32'(obs_w[i]), 32'(exp_q[i]));

    // second tick mid-frame
    nd0 = ndone;
    step(1, 0, rnd(), 0);
    idle(49);
    step(1, 0, rnd(), 0);
    run_to_done();
`ifdef OPERATOR_SCHEDULER_TICK_QUEUE_EN
    step(0, 0, rnd(), 0);
    check("queued_start", 32'({bus.o_FrameBusy, bus.o_VoiceOperatorValid}), 32'h3);
    run_to_done();
    check("queued_ovr", 32'(bus.o_Overrun), 32'd0);
    check("queued_frames", 32'(ndone - nd0), 32'd2);
`else
    idle(160);
    check("ovr_set", 32'(bus.o_Overrun), 32'd1);
    check("ovr_frames", 32'(ndone - nd0), 32'd1);
`endif

    // reset at ID 60 with two FIFO entries
    step(1, 0, rnd(), 0);
    idle(3);
    for (int i = 0; i < 2; i++) push_hold(rnd_w());
    k = 0;
    while (phase != 60 && k < 200) begin step(0, 0, rnd(), 0); k++; end
    check("reach_id60", 32'(bus.o_VoiceOperator), 32'd60);
    step(0, 0, rnd(), 1);
    check("rst_mid", 32'({bus.o_VoiceOperatorValid, bus.o_VoiceOperator, bus.o_FrameBusy, bus.o_FrameDone,
                          bus.o_Overrun, bus.o_AlgorithmWriteEnable, bus.o_AlgorithmWriteAddr,
                          bus.o_AlgorithmWriteData, bus.o_CfgReady}), 32'h1);
    nd0 = ndone; w0 = obs_w.size();
    idle(200);
    check("rst_no_done", 32'(ndone - nd0), 32'd0);
    check("rst_no_write", 32'(obs_w.size() - w0), 32'd0);

    // random ticks and config traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 249) == 0, $urandom_range(0, 2) == 0, rnd(), 0);
    idle(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
